// File: rtl/calc_operand_entry.sv
// Keypad entry stage: assembles two signed packed-BCD operands with decimal-point counts,
// latches the operator and pulses op_valid towards the BCD ALU on '='.
module calc_operand_entry #(
    parameter int MAX_DIGITS = 8,
    parameter int KEY_W      = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [KEY_W-1:0]        key_code,
    output logic                    sgn0,
    output logic [4*MAX_DIGITS-1:0] num0,
    output logic [3:0]              dp0,
    output logic                    sgn1,
    output logic [4*MAX_DIGITS-1:0] num1,
    output logic [3:0]              dp1,
    output logic [2:0]              operation,
    output logic                    op_valid,
    output logic                    disp_sgn,
    output logic [4*MAX_DIGITS-1:0] disp_num,
    output logic [3:0]              disp_dp,
    output logic [1:0]              state_o
);

    localparam int NW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [KEY_W-1:0] K_DOT   = KEY_W'(10);
    localparam logic [KEY_W-1:0] K_NEG   = KEY_W'(11);
    localparam logic [KEY_W-1:0] K_ADD   = KEY_W'(12);
    localparam logic [KEY_W-1:0] K_POW   = KEY_W'(16);
    localparam logic [KEY_W-1:0] K_EQ    = KEY_W'(17);
    localparam logic [KEY_W-1:0] K_CLEAR = KEY_W'(18);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } state_t;

    // ent records that the operand has received a digit or '.', even a suppressed leading zero.
    typedef struct packed {
        logic          sgn;
        logic [NW-1:0] num;
        logic [3:0]    dp;
        logic [CW-1:0] cnt;
        logic          dot;
        logic          ent;
    } operand_t;

    state_t     state_q, state_d;
    operand_t   opa_q, opa_d;
    operand_t   opb_q, opb_d;
    logic [2:0] oper_q, oper_d;
    logic       pulse_q, pulse_d;

    logic       is_digit, is_op;
    logic [3:0] digit;

    assign is_digit = (key_code < K_DOT);
    assign is_op    = (key_code >= K_ADD) && (key_code <= K_POW);
    assign digit    = key_code[3:0];

    function automatic operand_t apply_digit(input operand_t o, input logic [3:0] d);
        operand_t r;
        r = o;
        if (o.cnt == CW'(MAX_DIGITS)) begin
            r = o;
        end else if ((d == 4'd0) && (o.cnt == '0) && !o.dot) begin
            r.ent = 1'b1;
        end else begin
            r.num = {o.num[NW-5:0], d};
            r.cnt = o.cnt + CW'(1);
            r.ent = 1'b1;
            if (o.dot) r.dp = o.dp + 4'd1;
        end
        return r;
    endfunction

    function automatic operand_t apply_dot(input operand_t o);
        operand_t r;
        r = o;
        if (!o.dot) begin
            r.dot = 1'b1;
            r.ent = 1'b1;
        end
        return r;
    endfunction

    // State, operand, operator and pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ENTER_A;
            opa_q   <= '0;
            opb_q   <= '0;
            oper_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            oper_q  <= oper_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic for the FSM and the operand datapath it steers.
    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        oper_d  = oper_q;
        pulse_d = 1'b0;
        if (key_valid) begin
            if (key_code == K_CLEAR) begin
                state_d = ENTER_A;
                opa_d   = '0;
                opb_d   = '0;
                oper_d  = '0;
            end else begin
                unique case (state_q)
                    ENTER_A: begin
                        if (is_digit) begin
                            opa_d = apply_digit(opa_q, digit);
                        end else if (key_code == K_DOT) begin
                            opa_d = apply_dot(opa_q);
                        end else if (key_code == K_NEG) begin
                            opa_d.sgn = ~opa_q.sgn;
                        end else if (is_op && opa_q.ent) begin
                            oper_d  = 3'(key_code - K_ADD);
                            state_d = ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit) begin
                            opb_d = apply_digit(opb_q, digit);
                        end else if (key_code == K_DOT) begin
                            opb_d = apply_dot(opb_q);
                        end else if (key_code == K_NEG) begin
                            opb_d.sgn = ~opb_q.sgn;
                        end else if (is_op && !opb_q.ent) begin
                            oper_d = 3'(key_code - K_ADD);
                        end else if ((key_code == K_EQ) && opb_q.ent) begin
                            pulse_d = 1'b1;
                            state_d = DONE;
                        end
                    end
                    DONE: begin
                        // A fresh number starts a new calculation on the same edge.
                        if (is_digit) begin
                            opa_d   = apply_digit('0, digit);
                            opb_d   = '0;
                            state_d = ENTER_A;
                        end else if (key_code == K_DOT) begin
                            opa_d   = apply_dot('0);
                            opb_d   = '0;
                            state_d = ENTER_A;
                        end
                    end
                    default: begin
                        state_d = ENTER_A;
                    end
                endcase
            end
        end
    end

    // Output decode: ALU-facing operand set and the display mux.
    always_comb begin
        sgn0      = opa_q.sgn;
        num0      = opa_q.num;
        dp0       = opa_q.dp;
        sgn1      = opb_q.sgn;
        num1      = opb_q.num;
        dp1       = opb_q.dp;
        operation = oper_q;
        op_valid  = pulse_q;
        state_o   = state_q;
        if (state_q == ENTER_A) begin
            disp_sgn = opa_q.sgn;
            disp_num = opa_q.num;
            disp_dp  = opa_q.dp;
        end else begin
            disp_sgn = opb_q.sgn;
            disp_num = opb_q.num;
            disp_dp  = opb_q.dp;
        end
    end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed-vector bench for calc_operand_entry with hand-computed expectations.
module tb_calc_operand_entry;

    localparam logic [4:0] K_DOT = 5'd10, K_NEG = 5'd11, K_ADD = 5'd12, K_SUB = 5'd13;
    localparam logic [4:0] K_MUL = 5'd14, K_DIV = 5'd15, K_EQ = 5'd17, K_CLR = 5'd18;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic        sgn0, sgn1, disp_sgn, op_valid;
    logic [31:0] num0, num1, disp_num;
    logic [3:0]  dp0, dp1, disp_dp;
    logic [2:0]  operation;
    logic [1:0]  state_o;

    int n_pass = 0;
    int n_total = 0;
    int pulses = 0;
    int prev_pulses;
    logic last_ov = 1'b0;

    calc_operand_entry #(.MAX_DIGITS(8), .KEY_W(5)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .sgn0(sgn0), .num0(num0), .dp0(dp0),
        .sgn1(sgn1), .num1(num1), .dp1(dp1),
        .operation(operation), .op_valid(op_valid),
        .disp_sgn(disp_sgn), .disp_num(disp_num), .disp_dp(disp_dp),
        .state_o(state_o)
    );

    always #5 clock = ~clock;

    // Counts op_valid pulses and flags any back-to-back assertion.
    always @(negedge clock) begin
        if (op_valid) pulses++;
        if (op_valid && last_ov) $display("FAIL op_valid_consecutive: asserted two cycles in a row, required single pulse");
        last_ov <= op_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_num0", num0, 32'h0);
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_misc", {24'd0, sgn0, sgn1, op_valid, operation, state_o}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Test 1: 12.5 + 3 =
        press(5'd1); press(5'd2); press(K_DOT); press(5'd5);
        check("t1_disp_a", disp_num, 32'h125);
        press(K_ADD); press(5'd3);
        check("t1_state_b", {30'd0, state_o}, 32'd1);
        check("t1_disp_b", disp_num, 32'h3);
        prev_pulses = pulses;
        press(K_EQ);
        check("t1_op_valid", {31'd0, op_valid}, 32'd1);
        check("t1_num0", num0, 32'h125);
        check("t1_dp0", {28'd0, dp0}, 32'd1);
        check("t1_num1", num1, 32'h3);
        check("t1_dp1", {28'd0, dp1}, 32'd0);
        check("t1_oper", {29'd0, operation}, 32'd0);
        check("t1_state_done", {30'd0, state_o}, 32'd2);
        idle();
        check("t1_op_valid_drop", {31'd0, op_valid}, 32'd0);
        check("t1_pulse_count", pulses - prev_pulses, 32'd1);
        press(K_CLR);

        // Test 2: nine 9s saturate at eight digits
        for (int i = 0; i < 9; i++) press(5'd9);
        check("t2_num0", num0, 32'h99999999);
        press(K_DOT); press(5'd9);
        check("t2_full_num0", num0, 32'h99999999);
        check("t2_full_dp0", {28'd0, dp0}, 32'd0);
        press(K_CLR);
        check("t2_clear", num0, 32'h0);

        // Test 3: operator / +/- on empty A ignored, leading zeros and double dot
        press(K_DIV);
        check("t3_empty_op_state", {30'd0, state_o}, 32'd0);
        check("t3_empty_op_oper", {29'd0, operation}, 32'd0);
        press(K_NEG); press(K_ADD);
        check("t3_neg_not_entered", {30'd0, state_o}, 32'd0);
        press(K_NEG);
        press(5'd0); press(5'd0); press(K_DOT); press(K_DOT); press(5'd0); press(5'd7);
        check("t3_num0", num0, 32'h7);
        check("t3_dp0", {28'd0, dp0}, 32'd2);
        press(K_NEG);
        check("t3_sgn_neg", {31'd0, sgn0}, 32'd1);
        check("t3_disp_sgn", {31'd0, disp_sgn}, 32'd1);
        press(K_NEG);
        check("t3_sgn_pos", {31'd0, sgn0}, 32'd0);
        press(K_CLR);

        // Test 4: operator replacement, no chaining, single pulse
        press(5'd5); press(K_ADD); press(K_SUB);
        check("t4_oper_replaced", {29'd0, operation}, 32'd1);
        press(5'd2); press(K_MUL);
        check("t4_no_chain", {29'd0, operation}, 32'd1);
        check("t4_state_b", {30'd0, state_o}, 32'd1);
        prev_pulses = pulses;
        press(K_EQ);
        check("t4_op_valid", {31'd0, op_valid}, 32'd1);
        check("t4_operands", {num0[15:0], num1[15:0]}, 32'h0005_0002);
        press(K_EQ); press(K_NEG); idle();
        check("t4_pulse_count", pulses - prev_pulses, 32'd1);
        check("t4_done_hold", {sgn1, 15'd0, disp_num[15:0]}, 32'h0000_0002);

        // Test 6: digit in DONE starts a new A; clear in ENTER_B
        press(5'd4);
        check("t6_num0", num0, 32'h4);
        check("t6_num1", num1, 32'h0);
        check("t6_state", {30'd0, state_o}, 32'd0);
        press(K_MUL); press(5'd7);
        check("t6_oper", {29'd0, operation}, 32'd2);
        check("t6_disp_b", disp_num, 32'h7);
        press(K_CLR);
        check("t6_clear_nums", num0 | num1 | disp_num, 32'h0);
        check("t6_clear_misc", {26'd0, operation, state_o, op_valid}, 32'd0);

        // Test 5: async reset mid-entry of B
        press(5'd1); press(K_ADD); press(5'd2); press(5'd3);
        check("t5_pre_b", num1, 32'h23);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_nums", num0 | num1 | disp_num, 32'h0);
        check("t5_rst_state", {29'd0, operation, state_o}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        press(5'd6);
        check("t5_after_rst", num0, 32'h6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
